// File: rtl/spi_xfer_ctrl_if.sv
// Host-side command/response bundle for spi_xfer_ctrl.
// Both channels use valid/ready: a word moves on a rising clock edge where
// valid and ready are both high. Once valid is raised, the sender holds valid
// and its payload unchanged until that edge. Ready may be raised or lowered
// at any time, and it never depends combinationally on the valid signal.
interface spi_xfer_ctrl_if #(
  parameter int REG_WIDTH = 8,
  parameter int CW        = $clog2(REG_WIDTH)
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [REG_WIDTH-1:0] cmd_data;
  logic [CW:0]          cmd_size;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [REG_WIDTH-1:0] rsp_data;
  logic                 rsp_err;

  // Host side: issues commands and takes responses.
  modport master (
    output cmd_valid, cmd_data, cmd_size, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  // Controller side.
  modport slave (
    input  cmd_valid, cmd_data, cmd_size, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: queues host commands, runs one SPI engine transfer at a time,
// waits a fixed latency and captures the engine result as a response.
// The engine shares slave_clk, so the wait is cycle-counted. The engine's rstn
// is expected to be driven from ~rst at the level above, so both blocks reset
// together.
// Optional feature: define SPI_XFER_SIZE_CHECK_EN to reject a size of 0 or a
// size above REG_WIDTH. A rejected command is answered with rsp_err=1 and
// rsp_data=0, and it is never sent to the engine.
module spi_xfer_ctrl #(
  parameter int REG_WIDTH   = 8,
  parameter int CW          = $clog2(REG_WIDTH),
  parameter int DEPTH       = 4,
  parameter int CAPTURE_LAT = 3
) (
  input  logic                 slave_clk,
  input  logic                 rst,
  spi_xfer_ctrl_if.slave       host,
  output logic                 busy,
  output logic                 t_start,
  output logic [REG_WIDTH-1:0] d_in_s,
  output logic [CW:0]          t_size,
  input  logic [REG_WIDTH-1:0] d_out_s,
  output logic [1:0]           state_dbg
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = CW + 3;
  localparam int EW = CW + 1 + REG_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [EW-1:0]        mem [DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 full, empty, push, pop, load;
  logic [CW:0]          head_size;
  logic [REG_WIDTH-1:0] head_data;
  logic                 size_bad, cap_err;
  logic [WW-1:0]        wcnt, wcnt_nxt;
  logic                 rsp_valid, rsp_err;
  logic [REG_WIDTH-1:0] rsp_data;

  assign empty          = (wr_ptr == rd_ptr);
  assign full           = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Ready looks only at full, so a pop in the same cycle never frees a slot early.
  assign host.cmd_ready = !full && !rst;
  assign push           = host.cmd_valid && host.cmd_ready;
  assign {head_size, head_data} = mem[rd_ptr[AW-1:0]];

`ifdef SPI_XFER_SIZE_CHECK_EN
  localparam logic [CW:0] MAX_SIZE = (CW+1)'(REG_WIDTH);
  assign size_bad = (head_size == '0) || (head_size > MAX_SIZE);
`else
  assign size_bad = 1'b0;
`endif

  assign busy           = (state != IDLE) || !empty;
  assign state_dbg      = state;
  assign host.rsp_valid = rsp_valid;
  assign host.rsp_data  = rsp_data;
  assign host.rsp_err   = rsp_err;

  // FIFO storage. Entries are not reset because the pointers gate every read.
  always_ff @(posedge slave_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {host.cmd_size, host.cmd_data};
  end

  // FIFO pointers. A push into an empty FIFO becomes visible one cycle later.
  always_ff @(posedge slave_clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge slave_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, pop/load decode and wait counter update. The count already
  // runs during START. That makes CAPTURE land t_size+CAPTURE_LAT cycles
  // after START, so rsp_valid rises t_size+CAPTURE_LAT+2 cycles after the pop.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    wcnt_nxt  = wcnt;
    case (state)
      IDLE: begin
        if (!empty && !rsp_valid) begin
          pop = 1'b1;
          if (size_bad) begin
            state_nxt = CAPTURE;
          end else begin
            load      = 1'b1;
            state_nxt = START;
            wcnt_nxt  = WW'(head_size) + WW'(CAPTURE_LAT) - WW'(1);
          end
        end
      end
      START: begin
        if (wcnt == '0) begin
          state_nxt = CAPTURE;
        end else begin
          wcnt_nxt  = wcnt - WW'(1);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (wcnt == '0) state_nxt = CAPTURE;
        else            wcnt_nxt  = wcnt - WW'(1);
      end
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered engine drive, wait counter and response holding register.
  always_ff @(posedge slave_clk) begin
    if (rst) begin
      t_start   <= 1'b0;
      d_in_s    <= '0;
      t_size    <= '0;
      wcnt      <= '0;
      cap_err   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      t_start <= load;
      wcnt    <= wcnt_nxt;
      if (load) begin
        d_in_s <= head_data;
        t_size <= head_size;
      end
      if (pop) cap_err <= size_bad;
      if (state == CAPTURE) begin
        rsp_valid <= 1'b1;
        rsp_data  <= cap_err ? '0 : d_out_s;
        rsp_err   <= cap_err;
      end else if (rsp_valid && host.rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Testbench for spi_xfer_ctrl: table-driven single transfers plus hand-written
// sequences for a full FIFO, backpressure release and a reset during WAIT.
// The engine model returns d_in_s ^ 8'h99, latched on t_start.
module tb_spi_xfer_ctrl;
  localparam int RW = 8;

  logic          slave_clk = 1'b0;
  logic          rst = 1'b1;
  logic          busy, t_start;
  logic [RW-1:0] d_in_s, d_out_s;
  logic [3:0]    t_size;
  logic [1:0]    state_dbg;

  spi_xfer_ctrl_if #(.REG_WIDTH(RW)) bus ();

  spi_xfer_ctrl #(.REG_WIDTH(RW), .DEPTH(4), .CAPTURE_LAT(3)) dut (
    .slave_clk (slave_clk),
    .rst       (rst),
    .host      (bus),
    .busy      (busy),
    .t_start   (t_start),
    .d_in_s    (d_in_s),
    .t_size    (t_size),
    .d_out_s   (d_out_s),
    .state_dbg (state_dbg)
  );

  // Clock / cycle counter / engine model / t_start monitor.
  always #5 slave_clk = ~slave_clk;

  int cyc = 0;
  always @(posedge slave_clk) cyc <= cyc + 1;

  logic [RW-1:0] eng_q;
  always @(posedge slave_clk) begin
    if (rst)          eng_q <= '0;
    else if (t_start) eng_q <= d_in_s ^ 8'h99;
  end
  assign d_out_s = eng_q;

  int            start_q[$];
  logic [RW-1:0] din_q[$];
  logic [3:0]    tsz_q[$];
  always @(posedge slave_clk) begin
    if (t_start) begin
      start_q.push_back(cyc);
      din_q.push_back(d_in_s);
      tsz_q.push_back(t_size);
    end
  end

  // Scoreboard.
  int            n_checks = 0;
  int            n_fail = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_min(input string name, input int act, input int lo);
    n_checks++;
    if (act < lo) begin
      n_fail++;
      $display("FAIL %s: got %0d expected at least %0d", name, act, lo);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [3:0] size;
    bit         exp_start;
    logic [7:0] exp_data;
    bit         exp_err;
    int         exp_lat;    // push cycle to rsp_valid cycle
  } vec_t;

  vec_t vecs[7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            c0, rcyc, got, seen, last_din, last_tsz;
    logic [RW-1:0] rdat;
    logic          rerr, rbusy, busy_mid;

    // Push -> pop +1 cycle, so latency from push = t_size + 3 + 3.
    vecs[0] = '{8'hA5, 4'd8, 1'b1, 8'h3C, 1'b0, 14};
    vecs[1] = '{8'h80, 4'd1, 1'b1, 8'h19, 1'b0, 7};
    vecs[2] = '{8'h3C, 4'd4, 1'b1, 8'hA5, 1'b0, 10};
    vecs[3] = '{8'h0F, 4'd7, 1'b1, 8'h96, 1'b0, 13};
    vecs[4] = '{8'h5A, 4'd2, 1'b1, 8'hC3, 1'b0, 8};
`ifdef SPI_XFER_SIZE_CHECK_EN
    vecs[5] = '{8'h77, 4'd0, 1'b0, 8'h00, 1'b1, 3};
    vecs[6] = '{8'h11, 4'd9, 1'b0, 8'h00, 1'b1, 3};
`else
    vecs[5] = '{8'h77, 4'd0, 1'b1, 8'hEE, 1'b0, 6};
    vecs[6] = '{8'h11, 4'd9, 1'b1, 8'h88, 1'b0, 15};
`endif

    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_size  = '0;
    bus.rsp_ready = 1'b1;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge slave_clk);
    check("rst_cmd_ready_in_reset", bus.cmd_ready, 0);
    rst = 1'b0;
    @(negedge slave_clk);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_t_start", t_start, 0);
    check("rst_d_in_s", d_in_s, 0);
    check("rst_t_size", t_size, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_state", state_dbg, 0);

    // Table-driven single transfers.
    last_din = 0;
    last_tsz = 0;
    for (int v = 0; v < 7; v++) begin
      start_q.delete(); din_q.delete(); tsz_q.delete();
      @(negedge slave_clk);
      c0 = cyc;
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = vecs[v].data;
      bus.cmd_size  = vecs[v].size;
      @(negedge slave_clk);
      bus.cmd_valid = 1'b0;
      got = 0; busy_mid = 1'b0; rcyc = 0; rdat = '0; rerr = 1'b0; rbusy = 1'b1;
      for (int k = 0; k < 40; k++) begin
        if (cyc == c0 + 2) busy_mid = busy;
        if (bus.rsp_valid) begin
          got = 1; rcyc = cyc; rdat = bus.rsp_data; rerr = bus.rsp_err; rbusy = busy;
          break;
        end
        @(negedge slave_clk);
      end
      check($sformatf("v%0d_rsp_seen", v), got, 1);
      check($sformatf("v%0d_rsp_lat", v), rcyc - c0, vecs[v].exp_lat);
      check($sformatf("v%0d_rsp_data", v), rdat, vecs[v].exp_data);
      check($sformatf("v%0d_rsp_err", v), rerr, vecs[v].exp_err);
      check($sformatf("v%0d_busy_mid", v), busy_mid, 1);
      check($sformatf("v%0d_busy_after", v), rbusy, 0);
      check($sformatf("v%0d_start_cnt", v), start_q.size(), vecs[v].exp_start);
      if (vecs[v].exp_start && start_q.size() > 0) begin
        check($sformatf("v%0d_start_lat", v), start_q[0] - c0, 2);
        check($sformatf("v%0d_d_in_s", v), din_q[0], vecs[v].data);
        check($sformatf("v%0d_t_size", v), tsz_q[0], vecs[v].size);
        last_din = vecs[v].data;
        last_tsz = vecs[v].size;
      end else if (!vecs[v].exp_start) begin
        check($sformatf("v%0d_d_in_s_held", v), d_in_s, last_din);
        check($sformatf("v%0d_t_size_held", v), t_size, last_tsz);
      end
      @(negedge slave_clk);
    end

    // FIFO full with responses held back.
    start_q.delete(); din_q.delete(); tsz_q.delete();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge slave_clk);
      check($sformatf("full_ready_%0d", i), bus.cmd_ready, (i < 5) ? 1 : 0);
      if (bus.cmd_ready) exp_q.push_back(8'(8'h40 + i) ^ 8'h99);
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = 8'(8'h40 + i);
      bus.cmd_size  = 4'd8;
    end
    @(negedge slave_clk);
    bus.cmd_valid = 1'b0;
    repeat (20) @(negedge slave_clk);
    check("full_cmd_ready", bus.cmd_ready, 0);
    check("full_start_cnt", start_q.size(), 1);
    check("full_rsp_valid", bus.rsp_valid, 1);
    check("full_queued", exp_q.size(), 5);
    if (exp_q.size() > 0) check("full_rsp_data", bus.rsp_data, exp_q[0]);

    // Backpressure release: five ordered responses.
    bus.rsp_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 150 && got < 5; k++) begin
      if (bus.rsp_valid) begin
        if (exp_q.size() > 0) check($sformatf("rel_data_%0d", got), bus.rsp_data, exp_q.pop_front());
        got++;
      end
      @(negedge slave_clk);
    end
    check("rel_count", got, 5);
    check("rel_start_cnt", start_q.size(), 5);
    for (int i = 1; i < start_q.size(); i++)
      check_min($sformatf("rel_spacing_%0d", i), start_q[i] - start_q[i-1], 14);
    repeat (3) @(negedge slave_clk);
    check("rel_busy", busy, 0);

    // Reset four cycles after t_start, second command still queued.
    @(negedge slave_clk);
    bus.cmd_valid = 1'b1; bus.cmd_data = 8'hC3; bus.cmd_size = 4'd8;
    @(negedge slave_clk);
    bus.cmd_data = 8'h3C;
    @(negedge slave_clk);
    bus.cmd_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      if (t_start) begin got = 1; break; end
      @(negedge slave_clk);
    end
    check("rstw_start_seen", got, 1);
    repeat (4) @(negedge slave_clk);
    check("rstw_state_wait", state_dbg, 2);
    rst = 1'b1;
    @(negedge slave_clk);
    check("rstw_t_start", t_start, 0);
    check("rstw_d_in_s", d_in_s, 0);
    check("rstw_t_size", t_size, 0);
    check("rstw_rsp_valid", bus.rsp_valid, 0);
    check("rstw_busy", busy, 0);
    check("rstw_state", state_dbg, 0);
    rst = 1'b0;
    start_q.delete();
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge slave_clk);
      if (bus.rsp_valid) seen++;
    end
    check("rstw_no_rsp", seen, 0);
    check("rstw_no_start", start_q.size(), 0);
    check("rstw_fifo_empty", busy, 0);
    check("rstw_cmd_ready", bus.cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
